// File: rtl/branch_target_lut.sv
// Branch-target lookup table: DEPTH entries of PC address plus valid bit,
// written through a programming port, read through a one-cycle lookup port,
// and invalidated by a sequential one-entry-per-cycle clear sweep.
module branch_target_lut #(
  parameter int unsigned        IDX_W        = 8,
  parameter int unsigned        ADDR_W       = 16,
  parameter logic [ADDR_W-1:0]  DEFAULT_ADDR = '0
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Clear,
  input  logic              WrEn,
  input  logic [IDX_W-1:0]  WrIdx,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic              LkReq,
  input  logic [IDX_W-1:0]  LkIdx,
  output logic              LkReady,
  output logic              LkValid,
  output logic              LkHit,
  output logic [ADDR_W-1:0] PCAddr,
  output logic              Busy
);

  localparam int unsigned       DEPTH    = 2 ** IDX_W;
  localparam logic [IDX_W-1:0]  LAST_IDX = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  state_t              stateNext;
  logic [IDX_W-1:0]    sweepCnt;
  logic [DEPTH-1:0]    entryValid;
  logic [ADDR_W-1:0]   entryData [DEPTH];
  logic                lkAccept;
  logic                wrDo;
  logic                bypass;

  // Writes are only honoured in IDLE and never alongside a Clear request.
  assign lkAccept = LkReq & LkReady;
  assign wrDo     = WrEn & ~Busy & ~Clear;
  assign bypass   = wrDo && (WrIdx == LkIdx);

  // State register.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Next-state: start a sweep from IDLE, finish after the last index.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (Clear) stateNext = CLEAR;
      CLEAR:   if (sweepCnt == LAST_IDX) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    Busy    = (state == CLEAR);
    LkReady = (state != CLEAR);
  end

  // Sweep counter: steps once per CLEAR cycle and parks at zero when done.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sweepCnt <= '0;
    end else if (state == CLEAR) begin
      if (sweepCnt == LAST_IDX) sweepCnt <= '0;
      else                      sweepCnt <= sweepCnt + 1'b1;
    end
  end

  // Valid bits: cleared by reset and by the sweep, set by accepted writes.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      entryValid <= '0;
    end else if (state == CLEAR) begin
      entryValid[sweepCnt] <= 1'b0;
    end else if (wrDo) begin
      entryValid[WrIdx] <= 1'b1;
    end
  end

  // Entry data storage, intentionally not reset.
  always_ff @(posedge CLK) begin
    if (wrDo) entryData[WrIdx] <= WrAddr;
  end

  // Lookup result register; a same-cycle write to the looked-up index
  // is forwarded so the result reflects the new address.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      LkValid <= 1'b0;
      LkHit   <= 1'b0;
      PCAddr  <= DEFAULT_ADDR;
    end else begin
      LkValid <= lkAccept;
      if (lkAccept) begin
        if (bypass) begin
          LkHit  <= 1'b1;
          PCAddr <= WrAddr;
        end else if (entryValid[LkIdx]) begin
          LkHit  <= 1'b1;
          PCAddr <= entryData[LkIdx];
        end else begin
          LkHit  <= 1'b0;
          PCAddr <= DEFAULT_ADDR;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_target_lut.sv
// Scoreboard bench for branch_target_lut: stimulus pushes expected lookup
// results from a table model; a negedge monitor pops and compares them.
module tb_branch_target_lut;

  localparam int unsigned DEPTH = 256;

  logic        CLK;
  logic        Reset_n;
  logic        Clear, WrEn, LkReq;
  logic [7:0]  WrIdx, LkIdx;
  logic [15:0] WrAddr;
  logic        LkReady, LkValid, LkHit, Busy;
  logic [15:0] PCAddr;

  logic        c2Clear, c2WrEn, c2LkReq;
  logic [3:0]  c2WrIdx, c2LkIdx;
  logic [9:0]  c2WrAddr;
  logic        c2LkReady, c2LkValid, c2LkHit, c2Busy;
  logic [9:0]  c2PCAddr;

  branch_target_lut dut (
    .CLK(CLK), .Reset_n(Reset_n), .Clear(Clear), .WrEn(WrEn), .WrIdx(WrIdx),
    .WrAddr(WrAddr), .LkReq(LkReq), .LkIdx(LkIdx), .LkReady(LkReady),
    .LkValid(LkValid), .LkHit(LkHit), .PCAddr(PCAddr), .Busy(Busy)
  );

  branch_target_lut #(.IDX_W(4), .ADDR_W(10), .DEFAULT_ADDR(10'h3FF)) dut2 (
    .CLK(CLK), .Reset_n(Reset_n), .Clear(c2Clear), .WrEn(c2WrEn), .WrIdx(c2WrIdx),
    .WrAddr(c2WrAddr), .LkReq(c2LkReq), .LkIdx(c2LkIdx), .LkReady(c2LkReady),
    .LkValid(c2LkValid), .LkHit(c2LkHit), .PCAddr(c2PCAddr), .Busy(c2Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        hit;
    logic [15:0] addr;
  } res_t;

  res_t        expQ[$];
  res_t        lastRes;
  bit          refValid [DEPTH];
  logic [15:0] refData  [DEPTH];
  int          busyLeft;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pickIdx();
    logic [7:0] v;
    if ($urandom_range(0, 1) == 1) v = 8'($urandom_range(0, 7));
    else                           v = 8'($urandom);
    return v;
  endfunction

  task automatic modelReset();
    expQ.delete();
    for (int i = 0; i < DEPTH; i++) refValid[i] = 1'b0;
    busyLeft = 0;
    lastRes  = '{hit: 1'b0, addr: 16'h0000};
  endtask

  // One clock cycle: drive inputs, check status, predict, advance past the edge.
  task automatic step(input bit clr, input bit we, input logic [7:0] wi,
                      input logic [15:0] wa, input bit lr, input logic [7:0] li);
    bit   ready, accept, wrOk;
    res_t e;
    Clear = clr; WrEn = we; WrIdx = wi; WrAddr = wa; LkReq = lr; LkIdx = li;
    #1;
    chk("Busy", Busy, busyLeft > 0);
    chk("LkReady", LkReady, busyLeft == 0);
    ready  = (busyLeft == 0);
    accept = lr && ready;
    wrOk   = we && ready && !clr;
    if (accept) begin
      if (wrOk && wi == li)  e = '{hit: 1'b1, addr: wa};
      else if (refValid[li]) e = '{hit: 1'b1, addr: refData[li]};
      else                   e = '{hit: 1'b0, addr: 16'h0000};
      expQ.push_back(e);
    end
    if (busyLeft > 0) begin
      refValid[DEPTH - busyLeft] = 1'b0;
      busyLeft--;
    end else if (clr) begin
      busyLeft = DEPTH;
    end
    if (wrOk) begin
      refValid[wi] = 1'b1;
      refData[wi]  = wa;
    end
    @(posedge CLK);
    #1;
    Clear = 1'b0; WrEn = 1'b0; LkReq = 1'b0;
  endtask

  task automatic doReset(input bit withLookup);
    if (withLookup) begin
      LkReq = 1'b1;
      LkIdx = 8'h05;
    end
    Reset_n = 1'b0;
    #1;
    chk("rst Busy", Busy, 0);
    chk("rst LkReady", LkReady, 1);
    chk("rst LkValid", LkValid, 0);
    chk("rst LkHit", LkHit, 0);
    chk("rst PCAddr", PCAddr, 16'h0000);
    modelReset();
    @(posedge CLK);
    #1;
    LkReq   = 1'b0;
    Reset_n = 1'b1;
  endtask

  // Monitor: pop on every strobe, otherwise require held outputs.
  always @(negedge CLK) begin
    if (Reset_n) begin
      if (LkValid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected LkValid: got strobe expected none");
        end else begin
          lastRes = expQ.pop_front();
          chk("LkHit", LkHit, lastRes.hit);
          chk("PCAddr", PCAddr, lastRes.addr);
        end
      end else begin
        chk("hold LkHit", LkHit, lastRes.hit);
        chk("hold PCAddr", PCAddr, lastRes.addr);
      end
    end
  end

  initial begin
    int n;
    Clear = 0; WrEn = 0; LkReq = 0; WrIdx = 0; LkIdx = 0; WrAddr = 0;
    c2Clear = 0; c2WrEn = 0; c2LkReq = 0; c2WrIdx = 0; c2LkIdx = 0; c2WrAddr = 0;
    Reset_n = 1'b1;
    modelReset();
    #1;
    doReset(1'b0);

    // Miss after reset, accepted on the first edge after release.
    step(0, 0, 8'h00, 16'h0000, 1, 8'h05);
    // Write then lookup; then same-cycle write/lookup bypass.
    step(0, 1, 8'h05, 16'h0123, 0, 8'h00);
    step(0, 0, 8'h00, 16'h0000, 1, 8'h05);
    step(0, 1, 8'h05, 16'h0456, 1, 8'h05);
    step(0, 0, 8'h00, 16'h0000, 1, 8'h05);
    // Back-to-back lookups with two programmed entries and one empty one.
    step(0, 1, 8'h01, 16'hA001, 0, 8'h00);
    step(0, 1, 8'h02, 16'hA002, 0, 8'h00);
    step(0, 0, 8'h00, 16'h0000, 1, 8'h01);
    step(0, 0, 8'h00, 16'h0000, 1, 8'h02);
    step(0, 0, 8'h00, 16'h0000, 1, 8'h03);
    // Write dropped when issued with Clear; lookup same cycle sees old contents.
    step(0, 1, 8'h00, 16'h1111, 0, 8'h00);
    step(0, 1, 8'hFF, 16'h2222, 0, 8'h00);
    step(1, 1, 8'h07, 16'h7777, 1, 8'hFF);
    // Sweep window: lookups, writes and a second Clear are ignored.
    for (int i = 0; i < DEPTH; i++)
      step(i == 50, 1, 8'h00, 16'h3333, 1, 8'hFF);
    step(0, 0, 8'h00, 16'h0000, 1, 8'h00);
    step(0, 0, 8'h00, 16'h0000, 1, 8'hFF);
    step(0, 0, 8'h00, 16'h0000, 1, 8'h07);

    // Randomised traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1, pickIdx(),
           16'($urandom), $urandom_range(0, 3) != 0, pickIdx());

    // Reset at sweep cycle 100 aborts the sweep and clears every entry.
    while (busyLeft > 0) step(0, 0, 8'h00, 16'h0000, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 8'(i), 16'hB000 + 16'(i), 0, 8'h00);
    step(1, 0, 8'h00, 16'h0000, 0, 8'h00);
    for (int i = 0; i < 100; i++) step(0, 0, 8'h00, 16'h0000, 0, 8'h00);
    doReset(1'b1);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 16'h0000, 1, 8'(i));
    step(0, 0, 8'h00, 16'h0000, 0, 8'h00);

    // Narrow build: DEFAULT_ADDR on miss, 16-cycle sweep.
    c2LkReq = 1; c2LkIdx = 4'h3;
    @(posedge CLK); #1; c2LkReq = 0;
    chk("c2 LkValid", c2LkValid, 1);
    chk("c2 miss LkHit", c2LkHit, 0);
    chk("c2 miss PCAddr", c2PCAddr, 10'h3FF);
    c2WrEn = 1; c2WrIdx = 4'h3; c2WrAddr = 10'h155;
    @(posedge CLK); #1; c2WrEn = 0;
    c2LkReq = 1;
    @(posedge CLK); #1; c2LkReq = 0;
    chk("c2 hit PCAddr", c2PCAddr, 10'h155);
    c2Clear = 1;
    @(posedge CLK); #1; c2Clear = 0;
    n = 0;
    while (c2Busy && n < 100) begin
      n++;
      @(posedge CLK); #1;
    end
    chk("c2 sweep cycles", n, 16);
    c2LkReq = 1;
    @(posedge CLK); #1; c2LkReq = 0;
    chk("c2 post-clear LkHit", c2LkHit, 0);
    chk("c2 post-clear PCAddr", c2PCAddr, 10'h3FF);

    @(negedge CLK); #1;
    chk("scoreboard drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_target_lut.md
BRANCH_TARGET_LUT -- requirements
Module: branch_target_lut

Interface
REQ-001 Parameter IDX_W, default 8, lookup index width; table depth DEPTH = 2**IDX_W.
REQ-002 Parameter ADDR_W, default 16, width of each stored PC address.
REQ-003 Parameter DEFAULT_ADDR, default 0, ADDR_W-bit value returned on a miss.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  reset; asynchronous, active-low.
REQ-006 Clear  input  1  pulse: start a sequential invalidate sweep of all entries.
REQ-007 WrEn  input  1  write strobe for the programming port.
REQ-008 WrIdx  input  IDX_W  entry index to write.
REQ-009 WrAddr  input  ADDR_W  PC address to store.
REQ-010 LkReq  input  1  lookup request.
REQ-011 LkIdx  input  IDX_W  lookup index (branch-target code from data memory).
REQ-012 LkReady  output  1  block can accept a lookup this cycle.
REQ-013 LkValid  output  1  one-cycle strobe: PCAddr/LkHit carry a new result.
REQ-014 LkHit  output  1  looked-up entry was valid.
REQ-015 PCAddr  output  ADDR_W  looked-up target address.
REQ-016 Busy  output  1  clear sweep in progress.

Function
REQ-017 Storage: DEPTH entries of ADDR_W data plus one valid bit each; data bits not reset, valid bits cleared by reset and by the sweep.
REQ-018 FSM states IDLE and CLEAR; IDLE -> CLEAR when Clear=1 in IDLE; CLEAR -> IDLE after the entry at index DEPTH-1 is invalidated.
REQ-019 In CLEAR: a sweep counter starting at 0 invalidates one entry per cycle and increments by one; sweep lasts exactly DEPTH cycles; counter never wraps past DEPTH-1.
REQ-020 Busy=1 in every CLEAR cycle and 0 in IDLE; LkReady = ~Busy.
REQ-021 Clear asserted while in CLEAR is ignored (sweep does not restart).
REQ-022 Write: WrEn=1 in IDLE stores WrAddr at WrIdx and sets its valid bit, visible to lookups accepted in later cycles.
REQ-023 WrEn=1 in CLEAR, or together with Clear=1 in IDLE, is dropped (no state change).
REQ-024 Lookup accepted when LkReq=1 and LkReady=1; LkReq while LkReady=0 is dropped, not queued.
REQ-025 Latency 1: cycle after acceptance, LkValid=1 for exactly one cycle, LkHit = valid bit of LkIdx, PCAddr = entry data if hit else DEFAULT_ADDR.
REQ-026 Same-cycle accepted lookup and write to the same index: result is LkHit=1, PCAddr=WrAddr (write bypass).
REQ-027 Same-cycle Clear and accepted lookup in IDLE: lookup completes with pre-clear contents.
REQ-028 Back-to-back lookups accepted every cycle in IDLE; one result per cycle, in order.
REQ-029 PCAddr and LkHit hold the last result while LkValid=0.

Reset
REQ-030 On Reset_n=0, immediately: FSM to IDLE, sweep counter 0, all valid bits 0, LkValid=0, LkHit=0, PCAddr=DEFAULT_ADDR, Busy=0, LkReady=1.
REQ-031 Reset asserted mid-sweep or mid-lookup aborts the operation; no LkValid strobe follows release.
REQ-032 After Reset_n rises, lookups are accepted on the first clock edge.

Verification
REQ-033 After reset, lookup LkIdx=8'h05 -> next cycle LkValid=1, LkHit=0, PCAddr=16'h0000.
REQ-034 Write WrIdx=8'h05, WrAddr=16'h0123, lookup 8'h05 following cycle -> LkHit=1, PCAddr=16'h0123; same-cycle write 16'h0456 and lookup of 8'h05 -> PCAddr=16'h0456.
REQ-035 Program 8'h00 and 8'hFF, pulse Clear -> Busy=1 and LkReady=0 for exactly 256 cycles; LkReq/WrEn/second Clear in that window ignored; afterwards lookups of 8'h00 and 8'hFF miss.
REQ-036 Lookups 8'h01,8'h02,8'h03 on consecutive cycles with entries 16'hA001,16'hA002 programmed, 8'h03 unprogrammed -> LkValid high 3 cycles, PCAddr A001, A002, 0000, LkHit 1,1,0.
REQ-037 Reset_n pulsed low at sweep cycle 100 -> Busy=0 immediately, all entries miss, lookup accepted on first edge after release.
REQ-038 IDX_W=4, ADDR_W=10, DEFAULT_ADDR=10'h3FF build: sweep lasts 16 cycles, miss returns 10'h3FF.
